// File: rtl/morse_pkg.sv
// Shared types and timing constants for the Morse decoder.
package morse_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MARK  = 2'd1,
        ST_SPACE = 2'd2
    } state_e;

    localparam int          MAX_ELEMENTS     = 5;      // longest ITU character (digits)
    localparam int          DASH_MIN_UNITS   = 2;      // mark of >= 2 units is a dash
    localparam int          LETTER_GAP_UNITS = 2;      // space of 2 units ends a character
    localparam int          WORD_GAP_UNITS   = 3;      // further idle units that end a word
    localparam logic [7:0]  ASCII_SPACE      = 8'h20;

endpackage

// File: rtl/morse_lut.sv
// Combinational ITU Morse lookup: (element count, symbol) -> uppercase ASCII.
// The first element keyed sits at bit (len-1) of the symbol; dot = 0, dash = 1.
module morse_lut (
    input  logic [2:0] len_i,
    input  logic [4:0] sym_i,
    output logic [7:0] ascii_o,
    output logic       valid_o
);

    // Decode table; every pattern not listed maps to 0 and is reported invalid.
    always_comb begin
        ascii_o = 8'h00;
        case ({len_i, sym_i})
            8'b001_00000: ascii_o = 8'h45; // E .
            8'b001_00001: ascii_o = 8'h54; // T -
            8'b010_00000: ascii_o = 8'h49; // I ..
            8'b010_00001: ascii_o = 8'h41; // A .-
            8'b010_00010: ascii_o = 8'h4E; // N -.
            8'b010_00011: ascii_o = 8'h4D; // M --
            8'b011_00000: ascii_o = 8'h53; // S ...
            8'b011_00001: ascii_o = 8'h55; // U ..-
            8'b011_00010: ascii_o = 8'h52; // R .-.
            8'b011_00011: ascii_o = 8'h57; // W .--
            8'b011_00100: ascii_o = 8'h44; // D -..
            8'b011_00101: ascii_o = 8'h4B; // K -.-
            8'b011_00110: ascii_o = 8'h47; // G --.
            8'b011_00111: ascii_o = 8'h4F; // O ---
            8'b100_00000: ascii_o = 8'h48; // H ....
            8'b100_00001: ascii_o = 8'h56; // V ...-
            8'b100_00010: ascii_o = 8'h46; // F ..-.
            8'b100_00100: ascii_o = 8'h4C; // L .-..
            8'b100_00110: ascii_o = 8'h50; // P .--.
            8'b100_00111: ascii_o = 8'h4A; // J .---
            8'b100_01000: ascii_o = 8'h42; // B -...
            8'b100_01001: ascii_o = 8'h58; // X -..-
            8'b100_01010: ascii_o = 8'h43; // C -.-.
            8'b100_01011: ascii_o = 8'h59; // Y -.--
            8'b100_01100: ascii_o = 8'h5A; // Z --..
            8'b100_01101: ascii_o = 8'h51; // Q --.-
            8'b101_11111: ascii_o = 8'h30; // 0 -----
            8'b101_01111: ascii_o = 8'h31; // 1 .----
            8'b101_00111: ascii_o = 8'h32; // 2 ..---
            8'b101_00011: ascii_o = 8'h33; // 3 ...--
            8'b101_00001: ascii_o = 8'h34; // 4 ....-
            8'b101_00000: ascii_o = 8'h35; // 5 .....
            8'b101_10000: ascii_o = 8'h36; // 6 -....
            8'b101_11000: ascii_o = 8'h37; // 7 --...
            8'b101_11100: ascii_o = 8'h38; // 8 ---..
            8'b101_11110: ascii_o = 8'h39; // 9 ----.
            default:      ascii_o = 8'h00;
        endcase
    end

    assign valid_o = |ascii_o;

endmodule

// File: rtl/morse_decoder.sv
// Morse key decoder: synchronizes the key, times marks/spaces in units and
// emits one ASCII character (or a word space) per strobe.
module morse_decoder
    import morse_pkg::*;
#(
    parameter int unsigned UNIT_CYCLES = 1200000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       morse_in,
    output logic [7:0] ascii_data,
    output logic       ascii_data_strb,
    output logic       decode_error
);

    localparam int PW = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;

    logic          sync1_q, sync2_q, level_q;
    state_e        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [2:0]    unit_q, unit_d;
    logic [4:0]    sym_q, sym_d;
    logic [2:0]    cnt_q, cnt_d;
    logic          ovf_q, ovf_d;
    logic          word_q, word_d;
    logic [7:0]    ascii_q, ascii_d;
    logic          strb_q, strb_d;
    logic          err_q, err_d;

    logic          rise, fall, tick;
    logic [7:0]    lut_ascii;
    logic          lut_valid;

    assign rise = sync2_q & ~level_q;
    assign fall = ~sync2_q & level_q;
    assign tick = (presc_q == PW'(UNIT_CYCLES - 1));

    morse_lut u_lut (
        .len_i   (cnt_q),
        .sym_i   (sym_q),
        .ascii_o (lut_ascii),
        .valid_o (lut_valid)
    );

    // Next-state logic: unit timing, element capture and character/word emission.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        state_d = state_q;
        presc_d = tick ? '0 : presc_q + PW'(1);
        unit_d  = (tick && unit_q != 3'd7) ? unit_q + 3'd1 : unit_q;
        sym_d   = sym_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        word_d  = word_q;
        ascii_d = ascii_q;
        strb_d  = 1'b0;
        err_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (rise) begin
                    state_d = ST_MARK;
                    sym_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                    word_d  = 1'b0;
                end else if (word_q && tick && unit_q == 3'(WORD_GAP_UNITS - 1)) begin
                    ascii_d = ASCII_SPACE;
                    strb_d  = 1'b1;
                    word_d  = 1'b0;
                end
            end
            ST_MARK: begin
                if (fall) begin
                    state_d = ST_SPACE;
                    if (cnt_q == 3'(MAX_ELEMENTS)) begin
                        ovf_d = 1'b1;
                    end else begin
                        sym_d = {sym_q[3:0], unit_q >= 3'(DASH_MIN_UNITS)};
                        cnt_d = cnt_q + 3'd1;
                    end
                end
            end
            ST_SPACE: begin
                if (tick && unit_q == 3'(LETTER_GAP_UNITS - 1)) begin
                    if (lut_valid && !ovf_q) begin
                        ascii_d = lut_ascii;
                        strb_d  = 1'b1;
                        word_d  = 1'b1;
                    end else begin
                        err_d   = 1'b1;
                    end
                    state_d = ST_IDLE;
                    // A key-down landing on the gap tick starts the next character at once.
                    if (rise) begin
                        state_d = ST_MARK;
                        sym_d   = '0;
                        cnt_d   = '0;
                        ovf_d   = 1'b0;
                        word_d  = 1'b0;
                    end
                end else if (rise) begin
                    state_d = ST_MARK;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (state_d != state_q) begin
            presc_d = '0;
            unit_d  = '0;
        end
    end

    // State, counters, synchronizer and registered outputs; synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            state_q <= ST_IDLE;
            presc_q <= '0;
            unit_q  <= '0;
            sym_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            word_q  <= 1'b0;
            ascii_q <= 8'h00;
            strb_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            sync1_q <= morse_in;
            sync2_q <= sync1_q;
            level_q <= sync2_q;
            state_q <= state_d;
            presc_q <= presc_d;
            unit_q  <= unit_d;
            sym_q   <= sym_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            word_q  <= word_d;
            ascii_q <= ascii_d;
            strb_q  <= strb_d;
            err_q   <= err_d;
        end
    end

    assign ascii_data      = ascii_q;
    assign ascii_data_strb = strb_q;
    assign decode_error    = err_q;

endmodule

// File: tb/tb_morse_decoder.sv
// Self-checking bench for morse_decoder at UNIT_CYCLES=4.
module tb_morse_decoder;

    localparam int U = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       morse_in = 1'b0;
    logic [7:0] ascii_data;
    logic       ascii_data_strb;
    logic       decode_error;

    morse_decoder #(.UNIT_CYCLES(U)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .morse_in        (morse_in),
        .ascii_data      (ascii_data),
        .ascii_data_strb (ascii_data_strb),
        .decode_error    (decode_error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit         is_err;
        logic [7:0] ch;
    } ev_t;

    ev_t        exp_q[$];
    int         strb_cyc_q[$];
    logic [7:0] strb_dat_q[$];
    int         checks = 0;
    int         failures = 0;
    logic [7:0] exp_data = 8'h00;
    bit         rst_seen = 1'b0;
    int         last_fall = 0;

    // Reference ITU table, independent of the RTL encoding.
    string tab[36] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..",
                       ".---", "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.",
                       "...", "-", "..-", "...-", ".--", "-..-", "-.--", "--..",
                       "-----", ".----", "..---", "...--", "....-", ".....", "-....",
                       "--...", "---..", "----."};
    string alpha = "ABCDEFGHIJKLMNOPQRSTUVWXYZ0123456789";

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    function automatic void decode(input string pat, output bit ok, output logic [7:0] ch);
        ok = 1'b0;
        ch = 8'h00;
        foreach (tab[i]) begin
            if (tab[i] == pat) begin
                ok = 1'b1;
                ch = alpha[i];
            end
        end
    endfunction

    // Compare process: every cycle outside reset, DUT events must follow the model queue.
    always @(negedge clk) begin
        if (!rst_n) begin
            rst_seen = 1'b1;
        end else if (rst_seen) begin
            rst_seen = 1'b0;
            check("reset_data", ascii_data, 8'h00);
            check("reset_strb", ascii_data_strb, 1'b0);
            check("reset_err", decode_error, 1'b0);
            exp_data = 8'h00;
        end else begin
            check("strb_err_exclusive", ascii_data_strb & decode_error, 1'b0);
            if (ascii_data_strb || decode_error) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_event", {ascii_data_strb, decode_error}, 2'b00);
                end else begin
                    ev_t e;
                    e = exp_q.pop_front();
                    check("event_kind", decode_error, e.is_err);
                    if (ascii_data_strb) begin
                        check("strb_data", ascii_data, e.ch);
                        strb_cyc_q.push_back(cyc);
                        strb_dat_q.push_back(ascii_data);
                        if (!e.is_err) exp_data = e.ch;
                    end
                end
            end
            if (!ascii_data_strb) check("data_hold", ascii_data, exp_data);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic key_pattern(input string pat);
        for (int i = 0; i < pat.len(); i++) begin
            morse_in = 1'b1;
            tick((pat[i] == "-") ? 3 * U : U);
            morse_in = 1'b0;
            last_fall = cyc + 1;
            if (i < pat.len() - 1) tick(U);
        end
    endtask

    // Keys one character, then stays low for gap_units; gaps are either <= 3 or >= 6.
    task automatic send_char(input string pat, input int gap_units);
        bit ok;
        logic [7:0] ch;
        decode(pat, ok, ch);
        exp_q.push_back('{is_err: !ok, ch: ch});
        if (ok && gap_units >= 6) exp_q.push_back('{is_err: 1'b0, ch: 8'h20});
        key_pattern(pat);
        tick(gap_units * U);
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            tick(1);
            n++;
        end
        check(name, exp_q.size(), 0);
    endtask

    initial begin
        bit ok;
        logic [7:0] ch;

        // Pin the model with hand-computed entries.
        decode("...", ok, ch);   check("model_S", {ok, ch}, {1'b1, 8'h53});
        decode("-----", ok, ch); check("model_0", {ok, ch}, {1'b1, 8'h30});
        decode("..--", ok, ch);  check("model_bad4", ok, 1'b0);
        decode("......", ok, ch); check("model_bad6", ok, 1'b0);

        tick(3);
        rst_n = 1'b1;
        tick(2);

        // Single 'E' with latency and word-space timing.
        strb_cyc_q.delete();
        strb_dat_q.delete();
        send_char(".", 8);
        drain("drain_e");
        check("e_strb_count", strb_cyc_q.size(), 2);
        if (strb_cyc_q.size() >= 2) begin
            check_range("e_latency", strb_cyc_q[0] - last_fall, 8, 10);
            check("e_char", strb_dat_q[0], 8'h45);
            check("word_gap_delay", strb_cyc_q[1] - strb_cyc_q[0], 12);
            check("word_char", strb_dat_q[1], 8'h20);
        end

        // SOS with 3-unit letter gaps.
        send_char("...", 3);
        send_char("---", 3);
        send_char("...", 8);
        drain("drain_sos");
        check("sos_last", ascii_data, 8'h20);

        // Six dots overflow; ascii_data must stay at the space.
        send_char("......", 8);
        drain("drain_overflow");
        check("overflow_hold", ascii_data, 8'h20);

        // Invalid 4-element pattern, then digit zero.
        send_char("..--", 8);
        send_char("-----", 8);
        drain("drain_digits");

        // Reset mid-character discards the partial 'A'.
        morse_in = 1'b1; tick(U);
        morse_in = 1'b0; tick(U);
        morse_in = 1'b1; tick(3 * U);
        morse_in = 1'b0; tick(4);
        rst_n = 1'b0;    tick(1);
        rst_n = 1'b1;    tick(4 * U);
        check("after_reset_queue", exp_q.size(), 0);
        send_char(".-", 8);
        drain("drain_a");
        check("a_char", strb_dat_q[strb_dat_q.size() - 2], 8'h41);

        // Rise exactly on the 2-unit gap tick: 'E' then 'T'.
        send_char(".", 2);
        send_char("-", 8);
        drain("drain_coincident");

        // Very long mark saturates and decodes as dash.
        exp_q.push_back('{is_err: 1'b0, ch: 8'h54});
        exp_q.push_back('{is_err: 1'b0, ch: 8'h20});
        morse_in = 1'b1; tick(40);
        morse_in = 1'b0; tick(8 * U);
        drain("drain_long_mark");

        // Key held down across reset release behaves as a fresh rising edge.
        rst_n = 1'b0;
        morse_in = 1'b1;
        tick(2);
        rst_n = 1'b1;
        exp_q.push_back('{is_err: 1'b0, ch: 8'h54});
        exp_q.push_back('{is_err: 1'b0, ch: 8'h20});
        tick(3 * U);
        morse_in = 1'b0;
        tick(8 * U);
        drain("drain_reset_high");

        tick(10 * U);
        check("final_queue", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
